// File: rtl/instruction_fetch_stage.sv
// instruction_fetch_stage
//   Front of the pipeline. Holds the program counter, presents it to the
//   combinational instruction memory, picks the next PC and captures the
//   fetched word into the IF/ID register.
//
// Ports
//   Clk, Reset            rising-edge clock, synchronous active-high reset
//   Stall                 hold PC and IF/ID
//   BranchTaken/Target    redirect to branch target (lower priority than Jump)
//   Jump/JumpTarget       redirect to jump target (j, jal, jr)
//   ImemAddress           byte address to instruction memory (= PC)
//   ImemInstruction       word returned for ImemAddress
//   PC                    current program counter
//   IF_ID_Instruction     registered fetched word
//   IF_ID_PCPlus4         registered PC+4 of that word
//   IF_ID_Valid           1 = real instruction, 0 = bubble
module instruction_fetch_stage #(
   parameter logic [31:0] PC_RESET = 32'h0000_0000,
   parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Stall,
   input  logic        BranchTaken,
   input  logic [31:0] BranchTarget,
   input  logic        Jump,
   input  logic [31:0] JumpTarget,
   output logic [31:0] ImemAddress,
   input  logic [31:0] ImemInstruction,
   output logic [31:0] PC,
   output logic [31:0] IF_ID_Instruction,
   output logic [31:0] IF_ID_PCPlus4,
   output logic        IF_ID_Valid
);

   localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

   // RUN advances the PC; HOLD keeps everything. Decoded per cycle from the
   // inputs, never stored.
   typedef enum logic {MODE_RUN, MODE_HOLD} mode_e;
   mode_e mode;

   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pcp4_q, pcp4_d;
   logic        valid_q, valid_d;
   logic [31:0] pc_plus4;

   assign pc_plus4 = pc_q + 32'd4;   // wraps modulo 2^32

   always_comb begin
      mode    = MODE_RUN;
      pc_d    = pc_q;
      instr_d = instr_q;
      pcp4_d  = pcp4_q;
      valid_d = valid_q;
      if (Jump) begin
         // Jump wins over a simultaneous branch; wrong-path word is dropped.
         pc_d    = JumpTarget & ALIGN_MASK;
         instr_d = NOP_WORD;
         pcp4_d  = 32'd0;
         valid_d = 1'b0;
      end else if (BranchTaken) begin
         pc_d    = BranchTarget & ALIGN_MASK;
         instr_d = NOP_WORD;
         pcp4_d  = 32'd0;
         valid_d = 1'b0;
      end else if (Stall) begin
         mode = MODE_HOLD;
      end
      if (!Jump && !BranchTaken && mode == MODE_RUN) begin
         pc_d    = pc_plus4;
         instr_d = ImemInstruction;
         pcp4_d  = pc_plus4;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         pc_q    <= PC_RESET;
         instr_q <= NOP_WORD;
         pcp4_q  <= 32'd0;
         valid_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         instr_q <= instr_d;
         pcp4_q  <= pcp4_d;
         valid_q <= valid_d;
      end
   end

   assign ImemAddress       = pc_q;
   assign PC                = pc_q;
   assign IF_ID_Instruction = instr_q;
   assign IF_ID_PCPlus4     = pcp4_q;
   assign IF_ID_Valid       = valid_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
module tb_instruction_fetch_stage;

   logic        Clk = 1'b0;
   logic        Reset, Stall, BranchTaken, Jump;
   logic [31:0] BranchTarget, JumpTarget;
   logic [31:0] ImemAddress, ImemInstruction, PC;
   logic [31:0] IF_ID_Instruction, IF_ID_PCPlus4;
   logic        IF_ID_Valid;

   instruction_fetch_stage dut (
      .Clk(Clk), .Reset(Reset), .Stall(Stall),
      .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
      .Jump(Jump), .JumpTarget(JumpTarget),
      .ImemAddress(ImemAddress), .ImemInstruction(ImemInstruction),
      .PC(PC), .IF_ID_Instruction(IF_ID_Instruction),
      .IF_ID_PCPlus4(IF_ID_PCPlus4), .IF_ID_Valid(IF_ID_Valid)
   );

   always #5 Clk = ~Clk;

   // Instruction memory: mem[i] = A000_0000 + i, except two programmed words.
   logic [31:0] mem [1024];
   assign ImemInstruction = mem[ImemAddress[11:2]];

   typedef struct {
      string       name;
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] pcp4;
      logic        valid;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Monitor: every edge the DUT presents a new state; compare against the
   // oldest expected entry.
   initial begin
      exp_t e;
      forever begin
         @(posedge Clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++;
            if (PC !== e.pc || IF_ID_Instruction !== e.instr ||
                IF_ID_PCPlus4 !== e.pcp4 || IF_ID_Valid !== e.valid) begin
               n_fail++;
               $display("FAIL %s: got pc=%h ins=%h pcp4=%h v=%b, want pc=%h ins=%h pcp4=%h v=%b",
                        e.name, PC, IF_ID_Instruction, IF_ID_PCPlus4, IF_ID_Valid,
                        e.pc, e.instr, e.pcp4, e.valid);
            end
         end
      end
   end

   task automatic step(input string nm, input logic r, input logic s,
                       input logic b, input logic [31:0] bt,
                       input logic j, input logic [31:0] jt,
                       input logic [31:0] epc, input logic [31:0] ein,
                       input logic [31:0] ep4, input logic ev);
      exp_t e;
      @(negedge Clk);
      Reset = r; Stall = s; BranchTaken = b; BranchTarget = bt;
      Jump = j; JumpTarget = jt;
      e.name = nm; e.pc = epc; e.instr = ein; e.pcp4 = ep4; e.valid = ev;
      sb.push_back(e);
   endtask

   task automatic run(input string nm, input logic [31:0] epc,
                      input logic [31:0] ein, input logic [31:0] ep4);
      step(nm, 0, 0, 0, 0, 0, 0, epc, ein, ep4, 1);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 + i;
      mem[0] = 32'h0000_4820;
      mem[5] = 32'h2129_0006;
      Reset = 1; Stall = 0; BranchTaken = 0; BranchTarget = 0;
      Jump = 0; JumpTarget = 0;

      // Reset for two cycles
      step("reset1", 1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0);
      step("reset2", 1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0);

      // Sequential fetch, six edges
      run("seq1", 32'd4,  32'h0000_4820, 32'd4);
      run("seq2", 32'd8,  32'hA000_0001, 32'd8);
      run("seq3", 32'd12, 32'hA000_0002, 32'd12);
      run("seq4", 32'd16, 32'hA000_0003, 32'd16);
      run("seq5", 32'd20, 32'hA000_0004, 32'd20);
      run("seq6", 32'd24, 32'h2129_0006, 32'd24);

      // Back to PC = 8, then stall three cycles
      step("reset3", 1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0);
      run("pre_stall1", 32'd4, 32'h0000_4820, 32'd4);
      run("pre_stall2", 32'd8, 32'hA000_0001, 32'd8);
      step("stall1", 0, 1, 0, 0, 0, 0, 32'd8, 32'hA000_0001, 32'd8, 1);
      step("stall2", 0, 1, 0, 0, 0, 0, 32'd8, 32'hA000_0001, 32'd8, 1);
      step("stall3", 0, 1, 0, 0, 0, 0, 32'd8, 32'hA000_0001, 32'd8, 1);
      run("post_stall", 32'd12, 32'hA000_0002, 32'd12);

      // Branch during stall, unaligned target 0x43 -> 0x40
      step("br_stall", 0, 1, 1, 32'h43, 0, 0, 32'h40, 32'h0, 32'h0, 0);
      run("br_target", 32'h44, 32'hA000_0010, 32'h44);

      // Jump beats branch
      step("jmp_vs_br", 0, 0, 1, 32'h40, 1, 32'h100, 32'h100, 32'h0, 32'h0, 0);
      run("jmp_target", 32'h104, 32'hA000_0040, 32'h104);

      // Plain branch, no stall
      step("br_plain", 0, 0, 1, 32'h20, 0, 0, 32'h20, 32'h0, 32'h0, 0);
      run("br_plain_t", 32'h24, 32'hA000_0008, 32'h24);

      // Jump during stall to unaligned top of address space, then wrap
      step("jmp_top", 0, 1, 0, 0, 1, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h0, 32'h0, 0);
      run("wrap", 32'h0, 32'hA000_03FF, 32'h0);
      run("after_wrap", 32'h4, 32'h0000_4820, 32'h4);

      // Reset overrides concurrent jump and stall
      step("rst_jmp", 1, 1, 1, 32'h80, 1, 32'h200, 32'h0, 32'h0, 32'h0, 0);
      run("post_rst", 32'h4, 32'h0000_4820, 32'h4);

      // Drain: bounded wait for the monitor to consume everything
      for (int k = 0; k < 20 && sb.size() > 0; k++) @(posedge Clk);
      #2;
      if (sb.size() > 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: %0d entries left, want 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
